btn_conditioner: RTL

Front-end conditioning for the three board push-buttons; sits directly upstream of the load-pulse generator and the game-control logic. Each raw button is synchronised, debounced, and turned into a clean level (`btn`, the bus the load generator samples) plus one-cycle press, release and auto-repeat strobes used for held left/right/down moves. All three channels are identical and fully independent.

---
 rtl/btn_pkg.sv | 12 +
 rtl/btn_channel.sv | 81 ++++++++
 rtl/btn_conditioner.sv | 32 +++
 3 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared constants, repeat-FSM states and counter sizing for the button front end
package btn_pkg;
  localparam int NUM_BTN = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY = 25_000_000;
  localparam int DEF_REPEAT_PERIOD = 8_000_000;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debouncer, edge strobes and auto-repeat for one button
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic s1, s2, flip, rise, fall, rep_d;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt, rcnt_d;
  rep_state_t state, state_d;
  assign flip = (s2 != btn) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise = flip & s2;
  assign fall = flip & ~s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      dcnt <= '0;
      btn <= 1'b0;
      btn_press <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat <= 1'b0;
      state <= IDLE;
      rcnt <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      dcnt <= (s2 == btn || flip) ? '0 : dcnt + DW'(1);
      btn <= flip ? s2 : btn;
      btn_press <= rise;
      btn_release <= fall;
      btn_repeat <= rep_d;
      state <= state_d;
      rcnt <= rcnt_d;
    end
  end
  // Release is checked before expiry so no strobe escapes on the release edge
  always_comb begin
    state_d = state;
    rcnt_d = rcnt;
    rep_d = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_d = DELAY;
        rcnt_d = '0;
        rep_d = 1'b1;
      end
      DELAY: if (fall) begin
        state_d = IDLE;
        rcnt_d = '0;
      end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
        state_d = REPEAT;
        rcnt_d = '0;
        rep_d = 1'b1;
      end else rcnt_d = rcnt + RW'(1);
      REPEAT: if (fall) begin
        state_d = IDLE;
        rcnt_d = '0;
      end else if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
        rcnt_d = '0;
        rep_d = 1'b1;
      end else rcnt_d = rcnt + RW'(1);
      default: begin
        state_d = IDLE;
        rcnt_d = '0;
      end
    endcase
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: NUM_BTN independent button conditioning channels
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .btn_raw(btn_raw[i]),
      .btn(btn[i]),
      .btn_press(btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat(btn_repeat[i])
    );
  end
endmodule
